fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation pipelined RV32 core; replaces the combinational PC/increment/branch-select path of the single-cycle processor.
- Owns the fetch PC and issues requests to a handshaked instruction memory (multiple requests in flight).
- Buffers returned instructions in a prefetch FIFO and presents {pc, instr} to decode over a valid/ready interface.
- Supports branch/jump redirect with flush and discard of stale in-flight responses.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- FIFO_DEPTH, 4, prefetch buffer entries; power of 2, >=2.
- MAX_OUTSTANDING, 2, maximum imem requests in flight; 1..FIFO_DEPTH.

Ports:
- clock, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, reset; synchronous, active-low.
- redirect_valid, in, 1, branch/jump taken, from execute.
- redirect_pc, in, XLEN, new fetch target; bits [1:0] ignored (forced 0).
- imem_req_valid, out, 1, fetch request valid.
- imem_req_ready, in, 1, imem accepts request.
- imem_req_addr, out, XLEN, word-aligned fetch address.
- imem_rsp_valid, in, 1, response beat; in request order; no backpressure.
- imem_rsp_data, in, 32, instruction word.
- if_valid, out, 1, decode output valid.
- if_ready, in, 1, decode accepts.
- if_pc, out, XLEN, PC of the presented instruction.
- if_instr, out, 32, presented instruction.
- fifo_count, out, clog2(FIFO_DEPTH)+1, occupancy (status/debug).

Behaviour:
- Reset (rst=0 at an edge):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0.
  - Outputs: if_valid=0, imem_req_valid=0, fifo_count=0, imem_req_addr=RESET_PC, if_pc=0, if_instr=0.
  - Reset mid-operation abandons all in-flight requests; responses arriving after reset while outstanding=0 are ignored.
- Request issue:
  - imem_req_valid = !redirect_valid && outstanding<MAX_OUTSTANDING && (fifo_count+outstanding)<FIFO_DEPTH. The credit rule guarantees every response has a FIFO slot.
  - imem_req_addr = fetch_pc.
  - On req fire (valid&&ready): fetch_pc+=4 (wraps modulo 2^XLEN); outstanding++.
  - A held request keeps a stable address until accepted or withdrawn by redirect; imem must tolerate withdrawal.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - If discard>0, the beat is dropped and discard--.
  - Otherwise {pc_tag, data} is pushed into the FIFO. pc_tag comes from an internal in-flight PC queue (depth MAX_OUTSTANDING) popped on each response.
  - Response to issue latency >=1 cycle; a request and a response in the same cycle are both legal.
- Output:
  - if_valid = FIFO non-empty. if_pc/if_instr come from the FIFO head (registered storage, no comb path from imem).
  - Pop on if_valid&&if_ready. Push and pop in the same cycle are allowed, including when full (pop frees the slot).
  - Minimum latency from req fire to if_valid = imem latency + 1 cycle.
- Redirect (priority over all else that cycle):
  - FIFO flushed. Any pop that cycle is void; decode must treat that cycle's if handshake as killed.
  - fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - discard <= outstanding - (rsp fire this cycle ? 1 : 0); the response arriving in the redirect cycle is itself dropped.
  - No request is issued in the redirect cycle; the first new request is issued the next cycle.
  - Back-to-back redirects: the last one wins; discard is recomputed each time.
- Invariants (assert in the bench):
  - discard <= outstanding <= MAX_OUTSTANDING.
  - fifo_count + (outstanding - discard) <= FIFO_DEPTH.
  - A push never occurs when full; a pop never occurs when empty.

Test Plan:
- Reset then stream (imem 1-cycle latency, ready=1, if_ready=1) -> requests 0x0,0x4,0x8…; if_pc 0x0,0x4,0x8 on consecutive cycles after a 2-cycle startup.
- Backpressure (if_ready=0, FIFO_DEPTH=4, MAX_OUTSTANDING=2) -> exactly 4 requests fire; imem_req_valid stays 0 while fifo_count=4; release if_ready -> 4 pops in order, then fetch resumes at 0x10.
- Redirect to 0x203 with 2 requests outstanding, 3-cycle imem latency -> both stale responses dropped; next request addr 0x200; first if_pc=0x200; no stale instruction visible.
- Redirect coincident with a response beat and an if pop -> beat dropped, pop void, fifo_count=0 next cycle, discard=outstanding-1.
- imem_req_ready held 0 for 5 cycles -> addr stays stable; one accept advances fetch_pc by exactly 4.
- rst=0 asserted mid-stream with 2 outstanding -> next cycle if_valid=0, fifo_count=0, fetch_pc=RESET_PC; late responses are not pushed.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: imem request/response channel and decode output.
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [31:0]     imem_rsp_data;
   logic            if_valid;
   logic            if_ready;
   logic [XLEN-1:0] if_pc;
   logic [31:0]     if_instr;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data,
      output if_valid,
      output if_pc,
      output if_instr,
      input  if_ready
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data,
      input  if_valid,
      input  if_pc,
      input  if_instr,
      output if_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, pipelined imem requests, prefetch FIFO.
// Ports: clock, rst (sync active-low), redirect_valid/pc, bus, fifo_count.
module fetch_unit #(
   parameter int              XLEN            = 32,
   parameter logic [XLEN-1:0] RESET_PC        = '0,
   parameter int              FIFO_DEPTH      = 4,
   parameter int              MAX_OUTSTANDING = 2
) (
   input  logic                        clock,
   input  logic                        rst,
   input  logic                        redirect_valid,
   input  logic [XLEN-1:0]             redirect_pc,
   fetch_unit_if.master                bus,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
   logic [31:0]     instr_mem [FIFO_DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [CW-1:0]   count;

   // PCs of requests in flight, popped once per response beat
   logic [XLEN-1:0] tag_mem [MAX_OUTSTANDING];
   logic [QW-1:0]   tag_rd;
   logic [QW-1:0]   tag_wr;

   logic [OW-1:0]   outstanding;
   logic [OW-1:0]   discard;

   logic            req_fire;
   logic            rsp_fire;
   logic            push;
   logic            pop;
   logic [31:0]     credit_used;
   logic            unused_rpc_lsb;

   function automatic logic [QW-1:0] tag_inc(input logic [QW-1:0] p);
      if (32'(p) == MAX_OUTSTANDING - 1) return '0;
      return p + 1'b1;
   endfunction

   assign unused_rpc_lsb = ^redirect_pc[1:0];

   // every in-flight request already owns a FIFO slot
   assign credit_used = 32'(count) + 32'(outstanding);

   assign bus.imem_req_valid = rst && !redirect_valid
                            && (32'(outstanding) < MAX_OUTSTANDING)
                            && (credit_used < FIFO_DEPTH);
   assign bus.imem_req_addr  = fetch_pc;

   assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
   // beats with nothing in flight (e.g. after reset) are ignored
   assign rsp_fire = bus.imem_rsp_valid && (outstanding != '0);
   assign push     = rsp_fire && !redirect_valid && (discard == '0);
   assign pop      = bus.if_valid && bus.if_ready && !redirect_valid;

   assign bus.if_valid = (count != '0);
   assign bus.if_pc    = bus.if_valid ? pc_mem[rd_ptr]    : '0;
   assign bus.if_instr = bus.if_valid ? instr_mem[rd_ptr] : '0;
   assign fifo_count   = count;

   always_ff @(posedge clock) begin
      if (rst && req_fire) tag_mem[tag_wr] <= fetch_pc;
      if (rst && push) begin
         pc_mem[wr_ptr]    <= tag_mem[tag_rd];
         instr_mem[wr_ptr] <= bus.imem_rsp_data;
      end
   end

   always_ff @(posedge clock) begin
      if (!rst) begin
         fetch_pc    <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         tag_rd      <= '0;
         tag_wr      <= '0;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding + OW'(req_fire) - OW'(rsp_fire);
         if (rsp_fire) tag_rd <= tag_inc(tag_rd);
         if (req_fire) begin
            tag_wr   <= tag_inc(tag_wr);
            fetch_pc <= fetch_pc + XLEN'(4);
         end
         if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            // the beat landing this cycle is stale and consumed here
            discard  <= outstanding - OW'(rsp_fire);
            rd_ptr   <= wr_ptr;
            count    <= '0;
         end else begin
            if (rsp_fire && (discard != '0)) discard <= discard - 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: imem model, queue-based reference
// model compared every cycle, plus directed literal expectations.
module tb_fetch_unit;

   localparam int          DEPTH = 4;
   localparam int          MAXO  = 2;
   localparam logic [31:0] RPC   = 32'h0;

   logic        clock;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [2:0]  fifo_count;

   fetch_unit_if #(.XLEN(32)) bus ();

   fetch_unit #(
      .XLEN(32), .RESET_PC(RPC),
      .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clock(clock), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .bus(bus), .fifo_count(fifo_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
   typedef struct { int due; logic [31:0] addr; } pend_t;
   typedef struct { int cyc; logic [31:0] pc; } pop_t;

   ent_t        mfifo[$];
   logic [31:0] mtags[$];
   logic [31:0] m_pc;
   int          m_disc;
   bit          m_ok;

   pend_t       pend[$];
   logic [31:0] fire_log[$];
   pop_t        pop_log[$];
   int          lat;
   int          cyc;
   int          n_pass;
   int          n_total;

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return (a * 32'd7) ^ 32'h0000_0013;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
   endtask

   task automatic chk_pop(string name, int idx, logic [31:0] pc, int c);
      if (idx < pop_log.size()) begin
         chk(name, pop_log[idx].pc, pc);
         if (c >= 0) chk({name, "_cyc"}, pop_log[idx].cyc, c);
      end else chk({name, "_missing"}, pop_log.size(), idx + 1);
   endtask

   task automatic chk_fire(string name, int idx, logic [31:0] a);
      if (idx < fire_log.size()) chk(name, fire_log[idx], a);
      else chk({name, "_missing"}, fire_log.size(), idx + 1);
   endtask

   function automatic bit exp_req();
      return rst && !redirect_valid && mtags.size() < MAXO
          && (mfifo.size() + mtags.size()) < DEPTH;
   endfunction

   task automatic compare();
      if (!m_ok) return;
      chk("req_valid", bus.imem_req_valid, exp_req());
      chk("req_addr", bus.imem_req_addr, m_pc);
      chk("if_valid", bus.if_valid, mfifo.size() > 0);
      if (mfifo.size() > 0) begin
         chk("if_pc", bus.if_pc, mfifo[0].pc);
         chk("if_instr", bus.if_instr, mfifo[0].instr);
      end
      chk("fifo_count", fifo_count, mfifo.size());
      chk("outstanding", dut.outstanding, mtags.size());
      chk("discard", dut.discard, m_disc);
      chk("inv_disc_le_out", dut.discard <= dut.outstanding, 1);
      chk("inv_out_le_max", 32'(dut.outstanding) <= MAXO, 1);
      chk("inv_credit", 32'(fifo_count) + 32'(dut.outstanding)
          - 32'(dut.discard) <= DEPTH, 1);
      chk("inv_push_full", dut.push && !dut.pop && fifo_count == DEPTH, 0);
      chk("inv_pop_empty", dut.pop && fifo_count == 0, 0);
   endtask

   task automatic model_step();
      bit          req;
      bit          rsp;
      bit          pp;
      int          ob;
      logic [31:0] tag;
      if (!rst) begin
         mfifo.delete();
         mtags.delete();
         m_pc   = RPC;
         m_disc = 0;
         m_ok   = 1;
         return;
      end
      if (!m_ok) return;
      req = exp_req() && bus.imem_req_ready;
      rsp = bus.imem_rsp_valid && mtags.size() > 0;
      pp  = mfifo.size() > 0 && bus.if_ready && !redirect_valid;
      ob  = mtags.size();
      tag = '0;
      if (rsp) tag = mtags.pop_front();
      if (redirect_valid) begin
         mfifo.delete();
         m_pc   = redirect_pc & ~32'h3;
         m_disc = ob - int'(rsp);
      end else begin
         if (pp) begin
            pop_log.push_back('{cyc, mfifo[0].pc});
            void'(mfifo.pop_front());
         end
         if (rsp) begin
            if (m_disc > 0) m_disc--;
            else mfifo.push_back('{tag, bus.imem_rsp_data});
         end
         if (req) begin
            mtags.push_back(m_pc);
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic drive_rsp();
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = imem_word(pend[0].addr);
         void'(pend.pop_front());
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = '0;
      end
   endtask

   task automatic cycle();
      bit          fire;
      logic [31:0] fa;
      #1;
      compare();
      fire = bus.imem_req_valid && bus.imem_req_ready;
      fa   = bus.imem_req_addr;
      @(posedge clock);
      if (fire) begin
         pend.push_back('{cyc + lat, fa});
         fire_log.push_back(fa);
      end
      model_step();
      cyc++;
      @(negedge clock);
      drive_rsp();
   endtask

   task automatic fresh_reset();
      rst = 1'b0;
      redirect_valid = 1'b0;
      pend.delete();
      bus.imem_rsp_valid = 1'b0;
      cycle();
      cycle();
   endtask

   int rel;
   int nb;
   bit found;

   initial begin
      n_pass = 0; n_total = 0; cyc = 0; lat = 1; m_ok = 0;
      m_pc = RPC; m_disc = 0;
      rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      bus.imem_req_ready = 1'b1; bus.if_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;

      cycle();
      cycle();
      chk("rst_if_valid", bus.if_valid, 0);
      chk("rst_req_valid", bus.imem_req_valid, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_addr", bus.imem_req_addr, RPC);
      chk("rst_if_pc", bus.if_pc, 0);
      chk("rst_if_instr", bus.if_instr, 0);

      // stream, 1-cycle imem
      pop_log.delete();
      rst = 1'b1;
      rel = cyc;
      repeat (10) cycle();
      chk_pop("t1_pop0", 0, 32'h0, rel + 2);
      chk_pop("t1_pop1", 1, 32'h4, rel + 3);
      chk_pop("t1_pop2", 2, 32'h8, rel + 4);

      // decode backpressure
      fresh_reset();
      bus.if_ready = 1'b0;
      fire_log.delete();
      pop_log.delete();
      rst = 1'b1;
      repeat (10) cycle();
      chk("t2_fires", fire_log.size(), 4);
      chk("t2_full", fifo_count, 4);
      chk("t2_req_hold", bus.imem_req_valid, 0);
      fire_log.delete();
      bus.if_ready = 1'b1;
      repeat (6) cycle();
      chk_pop("t2_pop0", 0, 32'h0, -1);
      chk_pop("t2_pop1", 1, 32'h4, -1);
      chk_pop("t2_pop2", 2, 32'h8, -1);
      chk_pop("t2_pop3", 3, 32'hC, -1);
      chk_fire("t2_resume", 0, 32'h10);

      // redirect with two in flight, 3-cycle imem
      fresh_reset();
      lat = 3;
      rst = 1'b1;
      cycle();
      cycle();
      chk("t3_out", dut.outstanding, 2);
      redirect_valid = 1'b1;
      redirect_pc = 32'h203;
      fire_log.delete();
      pop_log.delete();
      cycle();
      redirect_valid = 1'b0;
      chk("t3_discard", dut.discard, 2);
      repeat (12) cycle();
      chk_fire("t3_first_req", 0, 32'h200);
      chk_pop("t3_first_pop", 0, 32'h200, -1);
      foreach (pop_log[i]) chk("t3_no_stale", pop_log[i].pc >= 32'h200, 1);

      // redirect coincident with beat and pop
      fresh_reset();
      lat = 2;
      bus.if_ready = 1'b0;
      rst = 1'b1;
      found = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.imem_rsp_valid && mtags.size() == 2 && mfifo.size() > 0) begin
            found = 1;
            break;
         end
         cycle();
      end
      chk("t4_found", found, 1);
      nb = pop_log.size();
      redirect_valid = 1'b1;
      redirect_pc = 32'h400;
      bus.if_ready = 1'b1;
      cycle();
      redirect_valid = 1'b0;
      chk("t4_count", fifo_count, 0);
      chk("t4_discard", dut.discard, 1);
      chk("t4_pop_void", pop_log.size(), nb);
      repeat (10) cycle();
      chk_pop("t4_first_pop", nb, 32'h400, -1);

      // imem stall holds the address
      fresh_reset();
      lat = 1;
      bus.imem_req_ready = 1'b0;
      fire_log.delete();
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("t5_addr_hold", bus.imem_req_addr, 32'h0);
      end
      bus.imem_req_ready = 1'b1;
      cycle();
      bus.imem_req_ready = 1'b0;
      chk("t5_addr_adv", bus.imem_req_addr, 32'h4);
      chk("t5_one_fire", fire_log.size(), 1);
      repeat (3) cycle();
      bus.imem_req_ready = 1'b1;

      // reset mid-stream with two in flight
      fresh_reset();
      lat = 3;
      rst = 1'b1;
      cycle();
      cycle();
      chk("t6_out", dut.outstanding, 2);
      rst = 1'b0;
      cycle();
      rst = 1'b1;
      bus.imem_req_ready = 1'b0;
      chk("t6_if_valid", bus.if_valid, 0);
      chk("t6_count", fifo_count, 0);
      chk("t6_addr", bus.imem_req_addr, RPC);
      nb = pop_log.size();
      repeat (6) cycle();
      chk("t6_late_count", fifo_count, 0);
      chk("t6_late_out", dut.outstanding, 0);
      bus.imem_req_ready = 1'b1;
      repeat (8) cycle();
      chk_pop("t6_restart", nb, 32'h0, -1);

      // redirect near the top of the address space wraps
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFF;
      fire_log.delete();
      cycle();
      redirect_valid = 1'b0;
      repeat (10) cycle();
      chk_fire("t7_top", 0, 32'hFFFF_FFFC);
      chk_fire("t7_wrap", 1, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
